vga_rx_monitor: RTL and testbench
=================================

// Module: vga_rx_monitor
// PURPOSE
//  Receive-side counterpart of the VGA output path. Samples vsync, hsync and
//  the 9-bit RGB333 vga_data stream (loopback or external source) on the
//  system clock and recovers line and frame timing.
//  Locks onto a stable raster, emits per-pixel x/y/data with a valid strobe,
//  reports measured clocks-per-line and lines-per-frame, and flags sync errors.
//  Used for SoC self-test of the display path and as a frame-capture front end.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line
//  V_ACTIVE  480  active lines per frame
//  H_BP      48   clocks from hsync trailing edge to first active pixel
//  V_BP      33   lines from vsync trailing edge to first active line
//  SYNC_POL  0    asserted sync level (0 = active-low syncs)
//  CNT_W     11   width of the h/v counters and measurement outputs
// PORTS
//  clk          in   1      system/pixel clock; only clock
//  rst          in   1      synchronous reset, active-high
//  hsync        in   1      horizontal sync, synchronous to clk
//  vsync        in   1      vertical sync, synchronous to clk
//  vga_data     in   9      RGB333 pixel
//  pix_valid    out  1      pix_* carry an active pixel this cycle
//  pix_x        out  CNT_W  active column, 0..H_ACTIVE-1
//  pix_y        out  CNT_W  active row, 0..V_ACTIVE-1
//  pix_data     out  9      sampled pixel
//  frame_start  out  1      1-cycle pulse on the cycle pix (0,0) is valid
//  line_clks    out  CNT_W  clocks per line, last completed line
//  frame_lines  out  CNT_W  lines per frame, last completed frame
//  locked       out  1      FSM in LOCKED
//  sync_err     out  1      1-cycle pulse: lock lost
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous and active-high.
//  - Reset: all outputs 0, FSM=SEARCH, counters 0, reference registers 0.
//  - Stage 0 registers hsync/vsync/vga_data. h_end = registered hsync goes
//    asserted->deasserted; v_end likewise for vsync.
//  - h_cnt: 0 on the cycle after h_end. The first input cycle with hsync
//    deasserted is column 0. Otherwise +1, saturating at 2^CNT_W-1.
//    Saturation is treated as a mismatch.
//  - On h_end: line_clks <= h_cnt+1; v_cnt <= v_cnt+1.
//  - On v_end: frame_lines <= v_cnt + h_end; v_cnt <= 0 (v_end wins).
//    An h_end in the same cycle belongs to the ending frame.
//  - FSM:
//    SEARCH : v_end -> ACQUIRE.
//    ACQUIRE: first h_end stores ref_h; later h_end != ref_h -> SEARCH.
//             v_end stores ref_v -> VERIFY.
//    VERIFY : any line != ref_h -> SEARCH.
//             v_end with frame count == ref_v -> LOCKED; else SEARCH.
//    LOCKED : line != ref_h, frame != ref_v, or h_cnt saturation ->
//             sync_err pulse 1 cycle, -> SEARCH.
//  - Pixel window: H_BP <= h_cnt < H_BP+H_ACTIVE and
//    V_BP <= v_cnt < V_BP+V_ACTIVE, gated by LOCKED.
//    pix_x = h_cnt-H_BP; pix_y = v_cnt-V_BP (CNT_W bits, no wrap inside window).
//  - Latency: input at clk edge k appears on pix_* after edge k+2; pix_* are
//    registered. pix_x/pix_y/pix_data hold their last values when pix_valid=0.
//  - Lock entry mid-frame never happens: LOCKED is entered only at v_end, so
//    the first valid pixel is always (0,0) with frame_start.
//  - rst mid-frame: immediate SEARCH, locked=0, pix_valid=0 next cycle.
//  - Syncs asserted continuously (no edges): no transitions. h_cnt saturates.
//    locked stays 0 or drops via saturation.
// TESTING  (H_ACTIVE=8 H_BP=2 V_ACTIVE=4 V_BP=1 CNT_W=8; line 16 clks,
//           hsync 2 clks; frame 8 lines, vsync 1 line)
//  1 Three clean frames -> locked=1 at v_end ending frame 2.
//    Frame 3: 32 pix_valid, x 0..7 / y 0..3, frame_start once with (0,0).
//    line_clks=16, frame_lines=8.
//  2 Data ramp vga_data=h_cnt in frame 3 -> pix_data equals 2..9 per line at
//    pix_x 0..7, exactly 2 cycles after input.
//  3 While locked, one line stretched to 17 clks -> sync_err pulses once.
//    locked=0 and pix_valid=0 thereafter; relocks after 2 clean frames.
//  4 While locked, frame shortened to 7 lines -> sync_err at that v_end,
//    SEARCH.
//  5 rst asserted mid-line of a locked frame -> next cycle all outputs 0.
//    Relocks on schedule of test 1.
//  6 SYNC_POL=1 with inverted syncs, hsync held asserted 300 clks ->
//    no lock until clean frames resume. No sync_err when never locked.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers line/frame timing from sampled VGA syncs, locks and emits located pixels
module vga_rx_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BP     = 48,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [8:0]       vga_data,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [8:0]       pix_data,
    output logic             frame_start,
    output logic [CNT_W-1:0] line_clks,
    output logic [CNT_W-1:0] frame_lines,
    output logic             locked,
    output logic             sync_err
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, VERIFY, LOCKED} state_t;
    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_BP);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_BP);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_BP + V_ACTIVE);
    logic hs_q, hs_qq, vs_q, vs_qq, have_ref;
    logic h_end, v_end, sat, h_bad, v_bad, win;
    logic [8:0] data_q, data_qq;
    logic [CNT_W-1:0] h_cnt, v_cnt, ref_h, ref_v, line_len, frame_len;
    state_t state, state_nx;

    assign h_end     = hs_qq == SYNC_POL && hs_q != SYNC_POL;
    assign v_end     = vs_qq == SYNC_POL && vs_q != SYNC_POL;
    assign line_len  = h_cnt + 1'b1;
    assign frame_len = v_cnt + CNT_W'(h_end);
    assign sat       = &h_cnt;
    assign h_bad     = h_end && line_len != ref_h;
    assign v_bad     = v_end && frame_len != ref_v;
    assign locked    = state == LOCKED;
    assign win       = locked && h_cnt >= H_LO && h_cnt < H_HI && v_cnt >= V_LO && v_cnt < V_HI;

    // Input stage plus one delay for edge detection; syncs idle deasserted so reset makes no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= !SYNC_POL;
            hs_qq   <= !SYNC_POL;
            vs_q    <= !SYNC_POL;
            vs_qq   <= !SYNC_POL;
            data_q  <= '0;
            data_qq <= '0;
        end else begin
            hs_q    <= hsync;
            hs_qq   <= hs_q;
            vs_q    <= vsync;
            vs_qq   <= vs_q;
            data_q  <= vga_data;
            data_qq <= data_q;
        end
    end

    // Raster counters and measurements; v_end wins over the h_end that closes the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_clks   <= '0;
            frame_lines <= '0;
        end else begin
            h_cnt <= h_end ? '0 : sat ? h_cnt : line_len;
            v_cnt <= v_end ? '0 : h_end ? v_cnt + 1'b1 : v_cnt;
            if (h_end) line_clks <= line_len;
            if (v_end) frame_lines <= frame_len;
        end
    end

    // Lock state register, reference capture and lock-loss pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            have_ref <= 1'b0;
            ref_h    <= '0;
            ref_v    <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nx;
            have_ref <= state == ACQUIRE && (have_ref || h_end);
            sync_err <= locked && state_nx == SEARCH;
            if (state == ACQUIRE && h_end && !have_ref) ref_h <= line_len;
            if (state == ACQUIRE && v_end) ref_v <= frame_len;
        end
    end

    // Next-state: a line mismatch in the closing cycle outranks the frame decision
    always_comb begin
        state_nx = state;
        case (state)
            SEARCH:  state_nx = v_end ? ACQUIRE : SEARCH;
            ACQUIRE: state_nx = (h_bad && have_ref) ? SEARCH : v_end ? VERIFY : ACQUIRE;
            VERIFY:  state_nx = (h_bad || v_bad) ? SEARCH : v_end ? LOCKED : VERIFY;
            default: state_nx = (h_bad || v_bad || sat) ? SEARCH : LOCKED;
        endcase
    end

    // Pixel outputs, one register after the counters; coordinates and data hold outside the window
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
        end else begin
            pix_valid   <= win;
            frame_start <= win && h_cnt == H_LO && v_cnt == V_LO;
            if (win) begin
                pix_x    <= h_cnt - H_LO;
                pix_y    <= v_cnt - V_LO;
                pix_data <= data_qq;
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed raster vectors against active-low and active-high sync instances
module tb_vga_rx_monitor;
    logic clk = 1'b0;
    logic rst, hs_a, vs_a;
    logic [8:0] vga_data;
    logic pv0, fs0, lk0, se0, pv1, fs1, lk1, se1;
    logic [7:0] px0, py0, lc0, fl0, px1, py1, lc1, fl1;
    logic [8:0] pd0, pd1;
    logic [44:0] outs0, outs1;
    int n_vec = 0, n_bad = 0;
    int n_pix, n_pix1, n_fs, n_pos_bad, n_err, n_err1, idx;

    always #5 clk = ~clk;

    vga_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BP(2), .V_BP(1), .SYNC_POL(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .hsync(~hs_a), .vsync(~vs_a), .vga_data(vga_data),
        .pix_valid(pv0), .pix_x(px0), .pix_y(py0), .pix_data(pd0), .frame_start(fs0),
        .line_clks(lc0), .frame_lines(fl0), .locked(lk0), .sync_err(se0));

    vga_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BP(2), .V_BP(1), .SYNC_POL(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .hsync(hs_a), .vsync(vs_a), .vga_data(vga_data),
        .pix_valid(pv1), .pix_x(px1), .pix_y(py1), .pix_data(pd1), .frame_start(fs1),
        .line_clks(lc1), .frame_lines(fl1), .locked(lk1), .sync_err(se1));

    assign outs0 = {pv0, px0, py0, pd0, fs0, lc0, fl0, lk0, se0};
    assign outs1 = {pv1, px1, py1, pd1, fs1, lc1, fl1, lk1, se1};

    // Pixel scoreboard: k-th valid pixel of a frame must be (k%8, k/8) carrying line*16+col
    always @(posedge clk) begin
        #1;
        if (pv0) begin
            n_pix++;
            if (px0 != 8'(idx % 8) || py0 != 8'(idx / 8) || pd0 != 9'((idx / 8 + 1) * 16 + idx % 8 + 2) || fs0 != (idx == 0))
                n_pos_bad++;
            idx++;
        end else if (fs0) n_pos_bad++;
        if (fs0) n_fs++;
        if (pv1) n_pix1++;
        if (se0) n_err++;
        if (se1) n_err1++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_pix = 0; n_pix1 = 0; n_fs = 0; n_pos_bad = 0; n_err = 0; n_err1 = 0; idx = 0;
    endtask

    task automatic put(input int line, input int col, input int len, input bit vs);
        hs_a = col >= len - 2;
        vs_a = vs;
        vga_data = 9'(line * 16 + col);
    endtask

    task automatic send_line(input int line, input int len, input bit vs, input int c0);
        for (int c = c0; c < len; c++) begin
            @(negedge clk);
            put(line, c, len, vs);
        end
    endtask

    task automatic send_frame(input int nl, input int long_line);
        for (int l = 0; l < nl; l++) send_line(l, l == long_line ? 17 : 16, l == nl - 1, 0);
    endtask

    initial begin
        rst = 1'b1; hs_a = 1'b0; vs_a = 1'b0; vga_data = '0;
        clr();
        repeat (3) @(negedge clk);
        chk("reset_outs0", 64'(outs0), 64'd0);
        chk("reset_outs1", 64'(outs1), 64'd0);
        rst = 1'b0;
        send_line(7, 16, 1'b1, 0);
        send_frame(8, -1);
        chk("acquire_nolock", 64'(lk0), 64'd0);
        send_frame(8, -1);
        chk("verify_nolock", 64'(lk0), 64'd0);
        clr();
        send_frame(8, -1);
        chk("lock", 64'(lk0), 64'd1);
        chk("lock_pol1", 64'(lk1), 64'd1);
        chk("f3_pix", 64'(n_pix), 64'd32);
        chk("f3_frame_start", 64'(n_fs), 64'd1);
        chk("f3_pos_data", 64'(n_pos_bad), 64'd0);
        chk("f3_pix_pol1", 64'(n_pix1), 64'd32);
        chk("line_clks", 64'(lc0), 64'd16);
        chk("frame_lines", 64'(fl0), 64'd8);
        clr();
        send_frame(8, 2);
        chk("stretch_err", 64'(n_err), 64'd1);
        chk("stretch_err_pol1", 64'(n_err1), 64'd1);
        chk("stretch_unlock", 64'(lk0), 64'd0);
        chk("stretch_pix", 64'(n_pix), 64'd16);
        clr();
        send_frame(8, -1);
        send_frame(8, -1);
        chk("relock_wait", 64'(lk0), 64'd0);
        chk("no_pix_unlocked", 64'(n_pix), 64'd0);
        chk("no_err_unlocked", 64'(n_err), 64'd0);
        clr();
        send_frame(8, -1);
        chk("relock", 64'(lk0), 64'd1);
        chk("relock_pix", 64'(n_pix), 64'd32);
        chk("relock_frame_start", 64'(n_fs), 64'd1);
        chk("relock_pos_data", 64'(n_pos_bad), 64'd0);
        clr();
        send_frame(7, -1);
        chk("short_pix", 64'(n_pix), 64'd32);
        chk("short_err_not_yet", 64'(n_err), 64'd0);
        send_frame(8, -1);
        chk("short_err", 64'(n_err), 64'd1);
        chk("short_unlock", 64'(lk0), 64'd0);
        chk("short_frame_lines", 64'(fl0), 64'd7);
        send_frame(8, -1);
        send_frame(8, -1);
        chk("short_relock_wait", 64'(lk0), 64'd0);
        send_line(0, 16, 1'b0, 0);
        send_line(1, 16, 1'b0, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            put(2, c, 16, 1'b0);
        end
        chk("pre_rst_lock", 64'(lk0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        put(2, 6, 16, 1'b0);
        chk("midrst_outs0", 64'(outs0), 64'd0);
        chk("midrst_outs1", 64'(outs1), 64'd0);
        send_line(2, 16, 1'b0, 7);
        for (int l = 3; l < 8; l++) send_line(l, 16, l == 7, 0);
        send_frame(8, -1);
        send_frame(8, -1);
        chk("rst_relock_wait", 64'(lk0), 64'd0);
        clr();
        send_frame(8, -1);
        chk("rst_relock", 64'(lk0), 64'd1);
        chk("rst_relock_pix", 64'(n_pix), 64'd32);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hs_a = 1'b1; vs_a = 1'b0;
        clr();
        repeat (300) @(negedge clk);
        chk("hold_nolock_pol1", 64'(lk1), 64'd0);
        chk("hold_nolock_pol0", 64'(lk0), 64'd0);
        chk("hold_noerr_pol1", 64'(n_err1), 64'd0);
        chk("hold_noerr_pol0", 64'(n_err), 64'd0);
        send_line(7, 16, 1'b1, 0);
        send_frame(8, -1);
        send_frame(8, -1);
        chk("pol1_prelock", 64'(lk1), 64'd0);
        clr();
        send_frame(8, -1);
        chk("pol1_lock", 64'(lk1), 64'd1);
        chk("pol1_pix", 64'(n_pix1), 64'd32);
        chk("pol1_noerr", 64'(n_err1), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
